// File: rtl/exu_div_ctrl.sv
// rtl/exu_div_ctrl.sv - RV64M divide-group controller with radix-2 restoring datapath
module exu_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_valid,
  input  logic [4:0]      i_div_info,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_rd_data,
  output logic [4:0]      o_rd_addr
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t            state;
  logic              is_rem_q;
  logic              word_q;
  logic [4:0]        rd_addr_q;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   rem;
  logic [6:0]        cnt;
  logic              q_neg;
  logic              r_neg;

  // Word results are always sign-extended from bit 31, signed or not
  function automatic logic [XLEN-1:0] fmt(input logic word, input logic [XLEN-1:0] x);
    fmt = word ? {{32{x[31]}}, x[31:0]} : x;
  endfunction

  logic            in_signed;
  logic            in_rem;
  logic            in_word;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] special_res;

  // Operand conditioning and special-case detection at accept
  always_comb begin
    in_signed = i_div_info[4] | i_div_info[2];
    in_rem    = i_div_info[2] | i_div_info[1];
    in_word   = i_div_info[0];
    if (in_word) begin
      a_ext = in_signed ? {{32{i_op1[31]}}, i_op1[31:0]} : {32'b0, i_op1[31:0]};
      b_ext = in_signed ? {{32{i_op2[31]}}, i_op2[31:0]} : {32'b0, i_op2[31:0]};
    end else begin
      a_ext = i_op1;
      b_ext = i_op2;
    end
    a_neg    = in_signed & a_ext[XLEN-1];
    b_neg    = in_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = in_signed & (b_ext == '1) &
               (a_ext == (in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    if (div_zero) special_res = in_rem ? a_ext : '1;
    else          special_res = in_rem ? '0 : a_ext;
    special_res = fmt(in_word, special_res);
  end

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] res_fin;

  // One restoring step: 65-bit trial subtract of the shifted partial remainder
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    diff    = rem_sh - {1'b0, dvs};
    q_fin   = q_neg ? -quo : quo;
    r_fin   = r_neg ? -rem : rem;
    res_fin = fmt(word_q, is_rem_q ? r_fin : q_fin);
  end

  // Handshake outputs decoded from state; stall is combinational on i_valid in IDLE
  always_comb begin
    o_ready = (state == IDLE);
    o_stall = ((state == IDLE) & i_valid) | (state == CALC) | (state == SIGN);
  end

  // Control FSM plus datapath registers; flush overrides every transition
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_rd_data <= '0;
      o_rd_addr <= '0;
      cnt       <= '0;
      is_rem_q  <= 1'b0;
      word_q    <= 1'b0;
      rd_addr_q <= '0;
      quo       <= '0;
      dvs       <= '0;
      rem       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_valid) begin
              is_rem_q  <= in_rem;
              word_q    <= in_word;
              rd_addr_q <= i_rd_addr;
              if (div_zero | ovf) begin
                o_rd_data <= special_res;
                o_rd_addr <= i_rd_addr;
                o_valid   <= 1'b1;
                state     <= DONE;
              end else begin
                // Word dividends sit in the top half so 32 shifts consume them
                quo   <= in_word ? {a_abs[31:0], 32'b0} : a_abs;
                dvs   <= b_abs;
                rem   <= '0;
                cnt   <= in_word ? 7'd32 : 7'd64;
                q_neg <= a_neg ^ b_neg;
                r_neg <= a_neg;
                state <= CALC;
              end
            end
          end
          CALC: begin
            rem <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], ~diff[XLEN]};
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) state <= SIGN;
          end
          SIGN: begin
            o_rd_data <= res_fin;
            o_rd_addr <= rd_addr_q;
            o_valid   <= 1'b1;
            state     <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exu_div_ctrl.sv
// tb/tb_exu_div_ctrl.sv - table-driven self-checking bench for exu_div_ctrl
module tb_exu_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [4:0]  i_div_info;
  logic [63:0] i_op1;
  logic [63:0] i_op2;
  logic [4:0]  i_rd_addr;
  logic        i_flush;
  logic        o_ready;
  logic        o_stall;
  logic        o_valid;
  logic [63:0] o_rd_data;
  logic [4:0]  o_rd_addr;

  exu_div_ctrl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_div_info(i_div_info),
    .i_op1(i_op1), .i_op2(i_op2), .i_rd_addr(i_rd_addr), .i_flush(i_flush),
    .o_ready(o_ready), .o_stall(o_stall), .o_valid(o_valid),
    .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr)
  );

  always #5 clock = ~clock;

  localparam logic [4:0] DIV  = 5'b10000;
  localparam logic [4:0] DIVU = 5'b01000;
  localparam logic [4:0] REM  = 5'b00100;
  localparam logic [4:0] REMU = 5'b00010;
  localparam logic [4:0] W    = 5'b00001;

  typedef struct {
    logic [4:0]  info;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; leaves the bench at the negedge after DONE
  task automatic run_op(input string name, input logic [4:0] info, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp_data, input int exp_lat);
    int k;
    int stall_err;
    bit seen;
    i_valid = 1'b1; i_div_info = info; i_op1 = a; i_op2 = b; i_rd_addr = rd;
    #1;
    chk({name, " ready_at_accept"}, {63'b0, o_ready}, 64'd1);
    chk({name, " stall_at_accept"}, {63'b0, o_stall}, 64'd1);
    @(posedge clock);
    #1 i_valid = 1'b0;
    seen = 0; stall_err = 0; k = 0;
    while (!seen && k < 100) begin
      @(negedge clock);
      k++;
      if (o_valid) begin
        seen = 1;
        if (o_stall !== 1'b0) stall_err++;
      end else if (o_stall !== 1'b1) begin
        stall_err++;
      end
    end
    chk({name, " latency"}, 64'(k), 64'(exp_lat));
    chk({name, " stall_pattern"}, 64'(stall_err), 64'd0);
    chk({name, " rd_data"}, o_rd_data, exp_data);
    chk({name, " rd_addr"}, {59'b0, o_rd_addr}, {59'b0, rd});
    @(negedge clock);
    chk({name, " valid_one_cycle"}, {63'b0, o_valid}, 64'd0);
    chk({name, " data_held"}, o_rd_data, exp_data);
  endtask

  int vbad;

  initial begin
    vecs[0]  = '{DIVU,     64'd100, 64'd7, 64'd14, 66};
    vecs[1]  = '{REMU,     64'd100, 64'd7, 64'd2, 66};
    vecs[2]  = '{DIV,      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[3]  = '{REM,      64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[4]  = '{DIVU,     64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{REM | W,  64'hAAAA_AAAA_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1};
    vecs[6]  = '{DIV,      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[7]  = '{DIV | W,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[8]  = '{REM | W,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{DIVU | W, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[10] = '{REM | W,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[11] = '{DIV | W,  64'd100, 64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 34};
    vecs[12] = '{DIVU,     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66};
    vecs[13] = '{REMU,     64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 66};
    vecs[14] = '{REM,      64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66};
    vecs[15] = '{DIVU | W, 64'hDEAD_BEEF_0000_0010, 64'h1234_5678_0000_0004, 64'd4, 34};

    reset = 1'b1; i_valid = 1'b0; i_div_info = '0; i_op1 = '0; i_op2 = '0;
    i_rd_addr = '0; i_flush = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset ready", {63'b0, o_ready}, 64'd1);
    chk("reset valid", {63'b0, o_valid}, 64'd0);
    chk("reset stall", {63'b0, o_stall}, 64'd0);
    chk("reset rd_data", o_rd_data, 64'd0);
    chk("reset rd_addr", {59'b0, o_rd_addr}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].info, vecs[i].op1, vecs[i].op2,
             5'(i + 1), vecs[i].exp_data, vecs[i].exp_lat);
    end

    // Flush mid-division: accept at T, flush sampled at end of T+10
    i_valid = 1'b1; i_div_info = DIV; i_op1 = 64'd1000; i_op2 = 64'd3; i_rd_addr = 5'd20;
    @(posedge clock);
    #1 i_valid = 1'b0;
    repeat (10) @(negedge clock);
    i_flush = 1'b1;
    @(negedge clock);
    i_flush = 1'b0;
    chk("flush ready", {63'b0, o_ready}, 64'd1);
    chk("flush stall", {63'b0, o_stall}, 64'd0);
    vbad = 0;
    repeat (70) begin
      @(negedge clock);
      if (o_valid !== 1'b0) vbad++;
    end
    chk("flush no_valid", 64'(vbad), 64'd0);
    run_op("after_flush", DIVU, 64'd9, 64'd3, 5'd21, 64'd3, 66);

    // Flush coinciding with i_valid in IDLE must not accept
    i_valid = 1'b1; i_flush = 1'b1; i_div_info = DIVU; i_op1 = 64'd5; i_op2 = 64'd0;
    i_rd_addr = 5'd9;
    @(negedge clock);
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_accept ready", {63'b0, o_ready}, 64'd1);
    chk("flush_accept valid", {63'b0, o_valid}, 64'd0);
    chk("flush_accept rd_addr", {59'b0, o_rd_addr}, 64'd21);

    // Reset mid-operation clears outputs and returns to IDLE
    i_valid = 1'b1; i_div_info = DIVU; i_op1 = 64'd50; i_op2 = 64'd5; i_rd_addr = 5'd3;
    @(posedge clock);
    #1 i_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreset ready", {63'b0, o_ready}, 64'd1);
    chk("midreset rd_data", o_rd_data, 64'd0);
    chk("midreset rd_addr", {59'b0, o_rd_addr}, 64'd0);
    chk("midreset valid", {63'b0, o_valid}, 64'd0);
    run_op("after_reset", REMU, 64'd50, 64'd6, 5'd4, 64'd2, 66);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
